// File: rtl/gamma_delay_pkg.sv
// Shared types and sizing helpers for the gamma-framed spike delay array.
// Build option GAMMA_DELAY_SATURATE_EN is consumed by gamma_delay_ch.
package gamma_delay_pkg;

    typedef enum logic [1:0] {
        ARMED,
        WAIT,
        FIRE,
        DONE
    } ch_state_t;

    // Pulse-length counter width; covers any PULSE_WIDTH up to 65536.
    localparam int unsigned PW_CNT_W = 16;

    function automatic int unsigned calc_dw(input int unsigned gamma_cycles);
        return $clog2(gamma_cycles);
    endfunction

endpackage

// File: rtl/gamma_delay_ch.sv
// One delay channel: first-edge capture, target compare, fixed-width pulse, sticky overflow.
// With GAMMA_DELAY_SATURATE_EN an overflowing edge fires at the last slot instead of dropping.
module gamma_delay_ch
    import gamma_delay_pkg::*;
#(
    parameter int unsigned GammaCycles = 16,
    parameter int unsigned PulseWidth  = 4,
    parameter int unsigned Dw          = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [Dw-1:0] g_cnt_i,
    input  logic          gamma_last_i,
    input  logic          rise_i,
    input  logic [Dw-1:0] delay_i,
    input  logic          ovf_clr_i,
    output logic          out_o,
    output logic          ovf_o
);

    // Latest target whose pulse still starts inside the gamma (at G-1).
    localparam logic [Dw:0]         LastTgt = (Dw + 1)'(GammaCycles - 2);
    localparam logic [PW_CNT_W-1:0] PwLast  = PW_CNT_W'(PulseWidth - 1);

    ch_state_t           state_q, state_d;
    logic [Dw-1:0]       tgt_q, tgt_d;
    logic [PW_CNT_W-1:0] pw_q, pw_d;
    logic                out_q, out_d;
    logic                ovf_q, ovf_d;

    logic [Dw:0]   sum;
    logic          over;
    logic          accept;
    logic [Dw-1:0] tgt_eff;

    assign sum  = {1'b0, g_cnt_i} + {1'b0, delay_i};
    assign over = sum > LastTgt;

`ifdef GAMMA_DELAY_SATURATE_EN
    assign accept  = 1'b1;
    assign tgt_eff = over ? LastTgt[Dw-1:0] : sum[Dw-1:0];
`else
    assign accept  = ~over;
    assign tgt_eff = sum[Dw-1:0];
`endif

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        pw_d    = pw_q;
        out_d   = out_q;
        ovf_d   = ovf_q & ~ovf_clr_i;
        case (state_q)
            ARMED: begin
                if (rise_i) begin
                    if (over) ovf_d = 1'b1;
                    if (!accept) begin
                        state_d = DONE;
                    end else if (tgt_eff == g_cnt_i) begin
                        // Zero effective delay: fire on the next cycle directly.
                        state_d = FIRE;
                        out_d   = 1'b1;
                        pw_d    = '0;
                    end else begin
                        state_d = WAIT;
                        tgt_d   = tgt_eff;
                    end
                end
            end
            WAIT: begin
                if (g_cnt_i == tgt_q) begin
                    state_d = FIRE;
                    out_d   = 1'b1;
                    pw_d    = '0;
                end
            end
            FIRE: begin
                if (pw_q == PwLast) begin
                    state_d = DONE;
                    out_d   = 1'b0;
                end else begin
                    pw_d = pw_q + PW_CNT_W'(1);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = ARMED;
        endcase
        if (gamma_last_i) begin
            state_d = ARMED;
            out_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARMED;
            tgt_q   <= '0;
            pw_q    <= '0;
            out_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            pw_q    <= pw_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_o = out_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/gamma_delay_array.sv
// NUM_CH-channel gamma-framed rising-edge delay; owns the phase counter and delay latch.
// Optional build macro GAMMA_DELAY_SATURATE_EN selects saturate-instead-of-drop on overflow.
module gamma_delay_array
    import gamma_delay_pkg::*;
#(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 4,
    parameter int unsigned NUM_CH            = 4,
    localparam int unsigned DW               = calc_dw(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 aclk,
    input  logic                 grst_n,
    input  logic [NUM_CH-1:0]    in,
    input  logic [NUM_CH*DW-1:0] delay,
    output logic [NUM_CH-1:0]    out,
    output logic                 gamma_start,
    output logic [NUM_CH-1:0]    ovf,
    input  logic                 ovf_clr
);

    logic [DW-1:0]        g_cnt_q, g_cnt_d;
    logic [NUM_CH*DW-1:0] delay_q, delay_d;
    logic [NUM_CH-1:0]    in_q;
    logic [NUM_CH-1:0]    rise;
    logic                 gamma_last;

    // G is a power of two, so the counter wraps G-1 -> 0 on its own.
    assign g_cnt_d     = g_cnt_q + DW'(1);
    assign gamma_start = (g_cnt_q == '0);
    assign gamma_last  = (g_cnt_q == DW'(GAMMA_CYCLE_WIDTH - 1));

    // Doubles as the effective delay: live input at gamma start, latched copy otherwise.
    assign delay_d = gamma_start ? delay : delay_q;
    assign rise    = in & ~in_q;

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            g_cnt_q <= '0;
            delay_q <= '0;
            in_q    <= '0;
        end else begin
            g_cnt_q <= g_cnt_d;
            delay_q <= delay_d;
            in_q    <= in;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gamma_delay_ch #(
            .GammaCycles(GAMMA_CYCLE_WIDTH),
            .PulseWidth (PULSE_WIDTH),
            .Dw         (DW)
        ) u_ch (
            .clk_i       (aclk),
            .rst_ni      (grst_n),
            .g_cnt_i     (g_cnt_q),
            .gamma_last_i(gamma_last),
            .rise_i      (rise[c]),
            .delay_i     (delay_d[c*DW +: DW]),
            .ovf_clr_i   (ovf_clr),
            .out_o       (out[c]),
            .ovf_o       (ovf[c])
        );
    end

endmodule

// File: tb/tb_gamma_delay_array.sv
// Scoreboard bench: a per-gamma pulse-window model predicts out/ovf/gamma_start every cycle.
module tb_gamma_delay_array;

    localparam int G   = 16;
    localparam int PW  = 4;
    localparam int NCH = 2;
    localparam int DW  = 4;

    logic           aclk;
    logic           grst_n;
    logic [NCH-1:0] in_s;
    logic [NCH*DW-1:0] delay_s;
    logic           ovf_clr_s;
    logic [NCH-1:0] out;
    logic           gamma_start;
    logic [NCH-1:0] ovf;

    gamma_delay_array #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH      (PW),
        .NUM_CH           (NCH)
    ) dut (
        .aclk       (aclk),
        .grst_n     (grst_n),
        .in         (in_s),
        .delay      (delay_s),
        .out        (out),
        .gamma_start(gamma_start),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr_s)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [NCH-1:0] out;
        logic [NCH-1:0] ovf;
        logic           gs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: phase, latched delay, one pulse window per channel per gamma.
    int m_g;
    bit m_prev  [NCH];
    int m_dly   [NCH];
    bit m_armed [NCH];
    int m_ps    [NCH];
    int m_pe    [NCH];
    bit m_ovf   [NCH];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_g = 0;
        for (int c = 0; c < NCH; c++) begin
            m_prev[c]  = 1'b0;
            m_dly[c]   = 0;
            m_armed[c] = 1'b1;
            m_ps[c]    = -1;
            m_pe[c]    = -1;
            m_ovf[c]   = 1'b0;
        end
    endtask

    // Advance the model by one clock with the currently driven inputs, then clock the DUT.
    task automatic step();
        exp_t e;
        int   d;
        int   tgt;
        bit   new_ovf;
        for (int c = 0; c < NCH; c++) begin
            new_ovf = 1'b0;
            d = (m_g == 0) ? int'(delay_s[c*DW +: DW]) : m_dly[c];
            if (m_g == 0) m_dly[c] = d;
            if (m_armed[c] && in_s[c] && !m_prev[c]) begin
                m_armed[c] = 1'b0;
                tgt = m_g + d;
                if (tgt > G - 2) begin
                    new_ovf = 1'b1;
`ifdef GAMMA_DELAY_SATURATE_EN
                    m_ps[c] = G - 1;
                    m_pe[c] = G - 1;
`endif
                end else begin
                    m_ps[c] = tgt + 1;
                    m_pe[c] = (tgt + PW > G - 1) ? G - 1 : tgt + PW;
                end
            end
            m_prev[c] = in_s[c];
            m_ovf[c]  = new_ovf || (m_ovf[c] && !ovf_clr_s);
            if (m_g == G - 1) begin
                m_armed[c] = 1'b1;
                m_ps[c]    = -1;
                m_pe[c]    = -1;
            end
        end
        m_g = (m_g + 1) % G;
        for (int c = 0; c < NCH; c++) begin
            e.out[c] = (m_ps[c] >= 0) && (m_g >= m_ps[c]) && (m_g <= m_pe[c]);
            e.ovf[c] = m_ovf[c];
        end
        e.gs = (m_g == 0);
        @(posedge aclk);
        sb.push_back(e);
        #1;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 2 * G && m_g != target; i++) step();
    endtask

    always @(negedge aclk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out", 4'(out), 4'(e.out));
            check("ovf", 4'(ovf), 4'(e.ovf));
            check("gamma_start", 4'(gamma_start), 4'(e.gs));
        end
    end

    initial begin
        grst_n    = 1'b0;
        in_s      = '0;
        delay_s   = '0;
        ovf_clr_s = 1'b0;
        model_reset();
        #1;
        check("rst_out", 4'(out), 4'd0);
        check("rst_ovf", 4'(ovf), 4'd0);
        check("rst_gamma_start", 4'(gamma_start), 4'd1);
        repeat (2) @(posedge aclk);
        #3;
        check("rst_hold_gamma_start", 4'(gamma_start), 4'd1);
        @(negedge aclk);
        #1 grst_n = 1'b1;

        // Basic delay on ch0; first-edge-only on ch1.
        delay_s = {4'd0, 4'd3};
        run_until(2);  in_s[0] = 1'b1;
        run_until(5);  in_s[1] = 1'b1;
        run_until(7);  in_s[1] = 1'b0;
        run_until(8);  in_s[1] = 1'b1;
        run_until(11); in_s = '0;
        run_until(0);

        // Overflow, sticky, set beats clear, then plain clear.
        delay_s = {4'd0, 4'd10};
        run_until(5); in_s[0] = 1'b1;
        run_until(0); in_s[0] = 1'b0;
        run_until(5); in_s[0] = 1'b1; ovf_clr_s = 1'b1;
        step();
        ovf_clr_s = 1'b0;
        run_until(9); ovf_clr_s = 1'b1;
        step();
        ovf_clr_s = 1'b0; in_s = '0;
        run_until(0);

        // Truncation at the gamma boundary, then the saturation case.
        delay_s = {4'd0, 4'd1};
        run_until(13); in_s[0] = 1'b1;
        run_until(0);  in_s = '0; delay_s = {4'd0, 4'd7};
        run_until(12); in_s[0] = 1'b1;
        run_until(0);  in_s = '0;

        // Mid-gamma delay change is ignored until the next gamma.
        delay_s = {4'd0, 4'd3};
        run_until(4);  delay_s = {4'd0, 4'd6};
        run_until(5);  in_s[0] = 1'b1;
        run_until(14); in_s = '0;
        run_until(5);  in_s[0] = 1'b1;
        run_until(0);  in_s = '0;

        // Asynchronous reset while ch0 is firing and ch1 has overflowed.
        delay_s = {4'd15, 4'd3};
        run_until(2); in_s = 2'b11;
        run_until(7);
        @(negedge aclk);
        #1 grst_n = 1'b0;
        #1;
        check("async_rst_out", 4'(out), 4'd0);
        check("async_rst_ovf", 4'(ovf), 4'd0);
        check("async_rst_gamma_start", 4'(gamma_start), 4'd1);
        model_reset();
        in_s    = '0;
        delay_s = '0;
        @(posedge aclk);
        @(negedge aclk);
        #1 grst_n = 1'b1;

        // Randomized traffic including mid-gamma delay changes and clears.
        for (int k = 0; k < 640; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(3) == 0) in_s[c] = ~in_s[c];
            end
            if ($urandom_range(7) == 0) delay_s = 8'($urandom);
            ovf_clr_s = ($urandom_range(15) == 0);
            step();
        end
        ovf_clr_s = 1'b0;

        @(negedge aclk);
        #1;
        check("scoreboard_drained", 4'(sb.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gamma_delay_array.md
Name: gamma_delay_array

Overview:
- NUM_CH-channel programmable rising-edge delay for temporal (race-logic) spike trains.
- A shared gamma-phase counter frames time. Each channel latches its delay at gamma start and honours only the first rising edge per gamma. It emits a fixed-width pulse delay+1 cycles after that edge.
- Replaces per-channel shift-register delay lines with a counter/comparator per channel. Sits between a column's input spike bus and its synaptic weight stage.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle G; power of 2, at least 4.
- PULSE_WIDTH, 4, output pulse length in cycles; 1 to G-1.
- NUM_CH, 4, number of independent channels.
- DW (localparam), $clog2(GAMMA_CYCLE_WIDTH), width of one delay/time field.

Ports:
- aclk  in  1  clock.
- grst_n  in  1  asynchronous active-low reset.
- in  in  NUM_CH  spike input per channel, synchronous to aclk.
- delay  in  NUM_CH*DW  per-channel delay; channel c uses bits [c*DW +: DW].
- out  out  NUM_CH  delayed pulse per channel, registered.
- gamma_start  out  1  high during the cycle where phase counter == 0.
- ovf  out  NUM_CH  sticky per channel: edge dropped because its pulse would start past gamma end.
- ovf_clr  in  1  synchronous clear of all ovf bits.

Behaviour:
- Reset (grst_n low, asynchronous): g_cnt=0, all channels in ARMED, delay_q=0, in_q=0, out=0, ovf=0. gamma_start follows g_cnt, so it reads 1 while in reset.
- Phase counter g_cnt (DW bits) increments every cycle and wraps G-1 -> 0. gamma_start = (g_cnt==0), combinational from g_cnt.
- Delay latch: in the cycle with g_cnt==0, delay_q[c] <= delay slice. delay_q is held for the rest of the gamma. Changes to delay mid-gamma are ignored.
- Edge detect: in_q <= in every cycle; rise[c] = in[c] & ~in_q[c]. in_q is not cleared at gamma boundaries.
- Per-channel FSM:
  - ARMED: on rise at g_cnt=t, compute tgt = t + d using a DW+1-bit sum, with d = (g_cnt==0 ? delay slice : delay_q).
  - If tgt <= G-2: go to WAIT, storing tgt.
  - Otherwise: set ovf[c], go to DONE.
  - WAIT: when g_cnt == tgt, go to FIRE and set out<=1. out is therefore high first in cycle g_cnt = t+d+1.
  - FIRE: out held high for exactly PULSE_WIDTH cycles (pulse-length counter), then out<=0 and go to DONE.
  - DONE: further rises are ignored until the next gamma.
- Gamma boundary: the transition g_cnt G-1 -> 0 forces every channel to ARMED and out<=0.
  - A pulse still in FIRE is truncated at the boundary.
  - A rise sampled at g_cnt==0 is evaluated in the new gamma.
- Simultaneous ovf_clr and a new overflow in the same cycle: the set wins.
- Latency: out goes high delay+1 cycles after the cycle in which in is first sampled high.
- Mid-operation reset: everything returns to reset values immediately; the first gamma starts when grst_n is released.

Optional Feature:
- Macro GAMMA_DELAY_SATURATE_EN.
- Defined: when tgt > G-2, the channel goes to WAIT with tgt = G-2 instead of dropping. The pulse then starts at g_cnt = G-1 and is truncated by the boundary to 1 cycle. ovf is still set as a warning.
- Undefined: the edge is dropped as described above.

Decomposition:
- Package gamma_delay_pkg holds:
  - channel state enum ch_state_t {ARMED, WAIT, FIRE, DONE};
  - a function computing DW from G;
  - localparam PW_CNT_W for the pulse-length counter width.
- One sub-module, gamma_delay_ch: a single channel's FSM, tgt register, pulse counter and ovf bit. It is instantiated NUM_CH times in a generate loop.
- Top level owns g_cnt, gamma_start, and the in_q/delay slicing.

Test Plan (G=16, PULSE_WIDTH=4, NUM_CH=2):
- Basic delay: delay ch0=3; in[0] rises at g_cnt=2 -> out[0] high exactly at g_cnt 6..9; ovf[0]=0.
- First-edge only: ch1 delay=0; rises at g_cnt=5 and g_cnt=8 -> single pulse at g_cnt 6..9; the second edge is ignored.
- Overflow: ch0 delay=10; rise at g_cnt=5 (tgt=15) -> no pulse, ovf[0]=1 and sticky. ovf_clr asserted in the same cycle as a new overflow leaves ovf[0]=1.
- Truncation / saturation:
  - Delay=1, rise at g_cnt=13 -> out high at g_cnt 15 only; out=0 at the next g_cnt=0.
  - With GAMMA_DELAY_SATURATE_EN, delay=7 and rise at g_cnt=12 -> out high at g_cnt=15 only, ovf=1.
- Delay latch: change delay 3->6 at g_cnt=4, rise at g_cnt=5 -> pulse starts at g_cnt 9 (delay 3 used). The next gamma uses 6.
- Async reset: drive grst_n low mid-FIRE -> out and ovf drop to 0 in the same cycle, g_cnt=0. After release, gamma_start pulses every 16 cycles.
